pixel_mem_arbiter: RTL and testbench
====================================

// Module: pixel_mem_arbiter
// PURPOSE
//  Shares the single-port pixel SRAM between two requesters:
//  - the pixel reader (9-pixel window fill and per-column refill)
//  - the gradient write-back path
//  Sits between the Sobel controller's datapath units and the memory.
//  One transaction in flight at a time; round-robin when both request.
// PARAMETERS
//  ADDR_W  16  SRAM address width
//  DATA_W  8   pixel/gradient data width
//  RD_LAT  2   SRAM read latency in cycles after mem_ren; legal 1..7
// PORTS
//  clk        in   1       system clock
//  n_rst      in   1       synchronous active-low reset
//  rd_req     in   1       read request; held until rd_grant
//  rd_addr    in   ADDR_W  read address; sampled on the granting edge
//  rd_grant   out  1       one-cycle pulse: read accepted
//  rd_data    out  DATA_W  captured read data; holds until next capture
//  rd_valid   out  1       one-cycle pulse: rd_data is valid
//  wr_req     in   1       write request; held until wr_grant
//  wr_addr    in   ADDR_W  write address; sampled on the granting edge
//  wr_data    in   DATA_W  write data; sampled on the granting edge
//  wr_grant   out  1       one-cycle pulse: write issued this cycle
//  mem_addr   out  ADDR_W  SRAM address (registered)
//  mem_wdata  out  DATA_W  SRAM write data (registered)
//  mem_ren    out  1       SRAM read enable, one cycle per read
//  mem_wen    out  1       SRAM write enable, one cycle per write
//  mem_rdata  in   DATA_W  SRAM read data, valid RD_LAT cycles after mem_ren
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset values:
//  - all outputs 0; state IDLE; lat counter 0
//  - last_grant = WRITE, so the first contended grant goes to read
//  - reset mid-operation drops the in-flight read: no rd_valid is produced
//  States: IDLE, RD_WAIT, RD_CAPT, WR_DONE. All outputs are registered.
//  Requests are sampled only in IDLE.
//  - A request deasserted before its grant is ignored; it is never an error.
//  IDLE, edge E0, one or both requests high:
//  - winner = the sole requester; if both, the one not equal to last_grant
//  - last_grant is updated to the winner
//  Read win:
//  - during C0: rd_grant=1, mem_ren=1, mem_addr=rd_addr
//  - next state RD_WAIT; counter loaded with RD_LAT-1
//  RD_WAIT:
//  - decrement the counter each cycle
//  - when the counter reaches 0, go to RD_CAPT, which is the cycle mem_rdata is valid
//  RD_CAPT:
//  - mem_rdata is captured into rd_data at the edge
//  - rd_valid=1 in the following cycle C(RD_LAT+1); state returns to IDLE
//  Read timing:
//  - rd_valid rises RD_LAT+1 cycles after rd_grant
//  - next grant no earlier than edge E(RD_LAT+2)
//  Write win:
//  - during C0: wr_grant=1, mem_wen=1, mem_addr=wr_addr, mem_wdata=wr_data
//  - next state WR_DONE, which lasts one cycle, then IDLE
//  - next grant no earlier than edge E2
//  mem_ren and mem_wen are never high together; each is high for exactly one cycle per grant.
//  mem_addr and mem_wdata hold their last values while idle.
//  busy is 0 only in IDLE.
//  A requester that holds its request continuously alternates with the other requester under contention. Neither starves.
// TESTING (RD_LAT=2, DATA_W=8)
//  1. Reset then idle; no requests for 10 cycles
//     -> all outputs 0, busy 0
//  2. rd_req=1, rd_addr=0x0123; SRAM returns 0x5A
//     -> rd_grant and mem_ren with mem_addr=0x0123 one cycle after the sampling edge
//     -> rd_valid with rd_data=0x5A 3 cycles after rd_grant
//  3. wr_req=1, wr_addr=0x0200, wr_data=0xFF
//     -> one-cycle mem_wen with mem_addr=0x0200, mem_wdata=0xFF, coincident with wr_grant
//     -> next grant no earlier than 2 cycles later
//  4. rd_req and wr_req both held high for 4 grants
//     -> grant order read, write, read, write
//     -> mem_ren and mem_wen never overlap
//  5. n_rst=0 for 1 cycle in the cycle after rd_grant
//     -> no rd_valid afterwards
//     -> state IDLE; busy 0 the cycle after reset
//  6. rd_req pulsed high for 1 cycle while busy with a write
//     -> no rd_grant and no mem_ren are generated

Source files
------------

// File: rtl/pixel_mem_arbiter.sv
`default_nettype none
// pixel_mem_arbiter: shares one single-port pixel SRAM between the window reader and the
// gradient write-back path. One transaction in flight at a time; round-robin on contention.
module pixel_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAPT = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              last_grant;
    logic              last_next;
    logic              pick_rd;
    logic              rd_grant_next;
    logic              wr_grant_next;
    logic              ren_next;
    logic              wen_next;
    logic              rd_valid_next;
    logic              busy_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] rd_data_next;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GRANT_WR;
            rd_grant   <= 1'b0;
            wr_grant   <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_data    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_next;
            rd_grant   <= rd_grant_next;
            wr_grant   <= wr_grant_next;
            mem_ren    <= ren_next;
            mem_wen    <= wen_next;
            rd_valid   <= rd_valid_next;
            busy       <= busy_next;
            mem_addr   <= addr_next;
            mem_wdata  <= wdata_next;
            rd_data    <= rd_data_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        last_next     = last_grant;
        rd_grant_next = 1'b0;
        wr_grant_next = 1'b0;
        ren_next      = 1'b0;
        wen_next      = 1'b0;
        rd_valid_next = 1'b0;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        rd_data_next  = rd_data;
        // Under contention the read wins only if the write went last.
        pick_rd       = rd_req && (!wr_req || (last_grant == GRANT_WR));

        case (state)
            IDLE: begin
                if (pick_rd) begin
                    state_next    = RD_WAIT;
                    cnt_next      = LAT_LOAD;
                    last_next     = GRANT_RD;
                    rd_grant_next = 1'b1;
                    ren_next      = 1'b1;
                    addr_next     = rd_addr;
                end else if (wr_req) begin
                    state_next    = WR_DONE;
                    last_next     = GRANT_WR;
                    wr_grant_next = 1'b1;
                    wen_next      = 1'b1;
                    addr_next     = wr_addr;
                    wdata_next    = wr_data;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_next = RD_CAPT;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RD_CAPT: begin
                rd_data_next  = mem_rdata;
                rd_valid_next = 1'b1;
                state_next    = IDLE;
            end
            WR_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_mem_arbiter.sv
`default_nettype none
// tb_pixel_mem_arbiter: directed vectors against a small SRAM model with RD_LAT=2.
module tb_pixel_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              n_rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int overlap_cnt = 0;
    int ren_cnt     = 0;
    int wen_cnt     = 0;

    pixel_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_grant (rd_grant),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_grant (wr_grant),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data appears RD_LAT cycles after mem_ren, 0xEE otherwise.
    logic [7:0] sram [0:255];
    logic       pv [0:RD_LAT-1];
    logic [7:0] pa [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
        pv[0] <= mem_ren;
        pa[0] <= mem_addr[7:0];
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign mem_rdata = pv[RD_LAT-1] ? sram[pa[RD_LAT-1]] : 8'hEE;

    always @(negedge clk) begin
        if (mem_ren && mem_wen) overlap_cnt++;
        if (mem_ren) ren_cnt++;
        if (mem_wen) wen_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, rd_grant, rd_valid, wr_grant, mem_ren, mem_wen, busy,
                rd_data, mem_addr, mem_wdata};
    endfunction

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Waits for rd_valid; returns cycles elapsed (0 on timeout).
    task automatic wait_valid(output int k);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                k = i;
                break;
            end
        end
    endtask

    int k;
    int ngr;
    int codes [0:3];
    int cycs  [0:3];
    int ren0;
    int wen0;
    int seen;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 8'h00;
        for (int i = 0; i < RD_LAT; i++) begin
            pv[i] = 1'b0;
            pa[i] = 8'h00;
        end
        sram[8'h23] = 8'h5A;
        rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
        n_rst = 0;

        // 1. reset then idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outs", all_outs(), 64'd0);
        end

        // 2. single read
        rd_req = 1; rd_addr = 16'h0123;
        @(negedge clk);
        check("rd_grant", {62'd0, rd_grant, mem_ren}, 64'd3);
        check("rd_mem_addr", mem_addr, 64'h0123);
        check("rd_busy", busy, 1);
        rd_req = 0;
        wait_valid(k);
        check("rd_valid_lat", k, RD_LAT + 1);
        check("rd_data", rd_data, 64'h5A);
        @(negedge clk);
        check("rd_valid_pulse", rd_valid, 0);
        check("rd_data_hold", rd_data, 64'h5A);
        check("rd_idle_busy", busy, 0);

        // 3. single write, then an immediate read request
        wr_req = 1; wr_addr = 16'h0200; wr_data = 8'hFF;
        @(negedge clk);
        check("wr_pulses", {59'd0, wr_grant, mem_wen, mem_ren, rd_grant, busy}, 64'h19);
        check("wr_mem_addr", mem_addr, 64'h0200);
        check("wr_mem_wdata", mem_wdata, 64'hFF);
        wr_req = 0; rd_req = 1; rd_addr = 16'h0200;
        @(negedge clk);
        check("wr_gap", {60'd0, rd_grant, mem_ren, mem_wen, busy}, 64'd0);
        @(negedge clk);
        check("rd_after_wr_grant", rd_grant, 1);
        rd_req = 0;
        wait_valid(k);
        check("rd_after_wr_lat", k, RD_LAT + 1);
        check("rd_after_wr_data", rd_data, 64'hFF);

        // 4. contention, both held for four grants
        do_reset();
        ren0 = ren_cnt; wen0 = wen_cnt;
        rd_req = 1; rd_addr = 16'h0010;
        wr_req = 1; wr_addr = 16'h0020; wr_data = 8'h33;
        ngr = 0;
        for (int i = 0; i < 4; i++) begin codes[i] = 0; cycs[i] = 0; end
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            @(negedge clk);
            if (rd_grant || wr_grant) begin
                codes[ngr] = (rd_grant ? 1 : 0) + (wr_grant ? 2 : 0);
                cycs[ngr]  = c;
                ngr++;
            end
        end
        rd_req = 0; wr_req = 0;
        repeat (3) @(negedge clk);
        check("rr_count", ngr, 4);
        check("rr_g0", codes[0], 1);
        check("rr_g1", codes[1], 2);
        check("rr_g2", codes[2], 1);
        check("rr_g3", codes[3], 2);
        check("rr_gap_rw", cycs[1] - cycs[0], RD_LAT + 2);
        check("rr_gap_wr", cycs[2] - cycs[1], 2);
        check("rr_gap_rw2", cycs[3] - cycs[2], RD_LAT + 2);
        check("rr_ren_pulses", ren_cnt - ren0, 2);
        check("rr_wen_pulses", wen_cnt - wen0, 2);
        check("rr_overlap", overlap_cnt, 0);

        // 5. reset in the cycle after rd_grant
        rd_req = 1; rd_addr = 16'h0123;
        @(negedge clk);
        check("rst_pre_grant", rd_grant, 1);
        rd_req = 0; n_rst = 0;
        @(negedge clk);
        check("rst_outs", all_outs(), 64'd0);
        n_rst = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid || busy) seen++;
        end
        check("rst_no_valid", seen, 0);

        // 6. read pulse while a write is in progress
        wr_req = 1; wr_addr = 16'h0040; wr_data = 8'h12;
        @(negedge clk);
        check("busy_wr_grant", wr_grant, 1);
        wr_req = 0; rd_req = 1; rd_addr = 16'h0041;
        @(negedge clk);
        rd_req = 0;
        ren0 = ren_cnt;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_grant) seen++;
        end
        check("pulse_no_grant", seen, 0);
        check("pulse_no_ren", ren_cnt - ren0, 0);
        check("final_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
